// File: rtl/copro_result_buffer_pkg.sv
// Shared constants and helpers for the coprocessor result buffer.
package copro_result_buffer_pkg;

    localparam int unsigned DefaultDepth = 4;
    localparam int unsigned DefaultXlen  = 32;
    localparam int unsigned RegAddrW     = 5;

    // Circular pointer increment: wraps from depth-1 back to 0, so the
    // depth does not have to be a power of two.
    function automatic int unsigned wrap_inc(input int unsigned ptr,
                                             input int unsigned depth);
        return (ptr == depth - 1) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/copro_result_buffer_if.sv
// Result channel from the buffer toward the core.
// Handshake: a transfer happens on every clock edge where valid and ready
// are both high; once valid is raised the producer holds valid and all
// payload fields unchanged until that transfer happens, and valid never
// depends combinationally on ready.
interface copro_result_buffer_if
    import copro_result_buffer_pkg::*;
#(
    parameter int unsigned XLEN = DefaultXlen,
    parameter type hartid_t = logic,
    parameter type id_t = logic
);
    logic                valid;
    logic                ready;
    logic [XLEN-1:0]     data;
    hartid_t             hartid;
    id_t                 id;
    logic [RegAddrW-1:0] rd;
    logic                we;

    // Buffer side drives the payload and valid.
    modport master (
        output valid, data, hartid, id, rd, we,
        input  ready
    );

    // Core side accepts results.
    modport slave (
        input  valid, data, hartid, id, rd, we,
        output ready
    );
endinterface

// File: rtl/copro_result_buffer.sv
// Result buffer: captures the non-stallable ALU result stream in a small
// circular FIFO and presents it on the core result channel. Issue credit
// accounts for the one result that may still be in flight in the ALU, so a
// well-behaved issuer can never overrun the buffer.
module copro_result_buffer
    import copro_result_buffer_pkg::*;
#(
    parameter int unsigned Depth = DefaultDepth,
    parameter int unsigned XLEN  = DefaultXlen,
    parameter type hartid_t = logic,
    parameter type id_t = logic
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          issue_fire_i,
    output logic                          issue_ready_o,
    input  logic                          alu_valid_i,
    input  logic [XLEN-1:0]               alu_result_i,
    input  hartid_t                       alu_hartid_i,
    input  id_t                           alu_id_i,
    input  logic [RegAddrW-1:0]           alu_rd_i,
    input  logic                          alu_we_i,
    copro_result_buffer_if.master         result_if,
    output logic [$clog2(Depth+1)-1:0]    count_o,
    output logic                          overflow_o
);

    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned CntW = $clog2(Depth + 1);
    localparam logic [CntW-1:0] DepthCnt  = Depth[CntW-1:0];
    localparam logic [CntW:0]   DepthWide = Depth[CntW:0];

    typedef struct packed {
        logic [XLEN-1:0]     data;
        hartid_t             hartid;
        id_t                 id;
        logic [RegAddrW-1:0] rd;
        logic                we;
    } entry_t;

    entry_t          mem_q [Depth];
    entry_t          mem_d [Depth];
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0] count_q, count_d;
    logic            inflight_q, inflight_d;
    logic            overflow_q, overflow_d;

    logic            not_empty;
    logic            full;
    logic            pop;
    logic            do_push;
    logic [CntW:0]   credit_need;
    entry_t          alu_entry;
    entry_t          head;

    // Occupancy decode, handshake qualification and issue credit.
    always_comb begin
        not_empty = (count_q != '0);
        full      = (count_q == DepthCnt);
        pop       = not_empty & result_if.ready;
        // A push on a full buffer only lands if the head leaves this cycle.
        do_push   = alu_valid_i & (~full | pop);
        // Entries that will still be held next cycle plus the pending ALU
        // result must leave room for one more.
        credit_need = {1'b0, count_q}
                    - {{CntW{1'b0}}, pop}
                    + {{CntW{1'b0}}, inflight_q};
        issue_ready_o = (credit_need < DepthWide);
    end

    // Next-state for storage, pointers, occupancy, in-flight and error flag.
    always_comb begin
        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        inflight_d = inflight_q;
        overflow_d = overflow_q;

        alu_entry.data   = alu_result_i;
        alu_entry.hartid = alu_hartid_i;
        alu_entry.id     = alu_id_i;
        alu_entry.rd     = alu_rd_i;
        alu_entry.we     = alu_we_i;

        if (do_push) begin
            mem_d[wr_ptr_q] = alu_entry;
            wr_ptr_d = PtrW'(wrap_inc(32'(wr_ptr_q), Depth));
        end
        if (pop) begin
            rd_ptr_d = PtrW'(wrap_inc(32'(rd_ptr_q), Depth));
        end

        case ({do_push, pop})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase

        if (alu_valid_i && !do_push) begin
            overflow_d = 1'b1;
        end

        // A new issue in the same cycle as the previous result keeps one
        // result pending.
        if (issue_fire_i) begin
            inflight_d = 1'b1;
        end else if (alu_valid_i) begin
            inflight_d = 1'b0;
        end
    end

    // State registers; reset also clears storage so the head reads as zero.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < int'(Depth); i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            inflight_q <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            mem_q      <= mem_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            inflight_q <= inflight_d;
            overflow_q <= overflow_d;
        end
    end

    // Head entry straight from storage: valid depends only on registered state.
    always_comb begin
        head             = mem_q[rd_ptr_q];
        result_if.valid  = not_empty;
        result_if.data   = head.data;
        result_if.hartid = head.hartid;
        result_if.id     = head.id;
        result_if.rd     = head.rd;
        result_if.we     = head.we;
        count_o          = count_q;
        overflow_o       = overflow_q;
    end

endmodule

// File: tb/tb_copro_result_buffer.sv
// Self-checking bench for copro_result_buffer (Depth 4, 2-bit hart, 4-bit id).
module tb_copro_result_buffer;

    localparam int DEPTH = 4;
    localparam int EW    = 44;   // data32 + hart2 + id4 + rd5 + we1

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic fire = 1'b0;
    logic av = 1'b0;
    logic ready = 1'b0;
    logic [EW-1:0] a_entry = '0;

    logic       issue_ready;
    logic [2:0] count;
    logic       overflow;

    int n_vec = 0;
    int n_err = 0;

    // reference model: ordered list of stored entries plus credit/error state
    logic [EW-1:0] exp_q[$];
    int   m_inflight = 0;
    logic m_ovf = 1'b0;

    always #5 clk = ~clk;

    copro_result_buffer_if #(.XLEN(32), .hartid_t(logic [1:0]), .id_t(logic [3:0])) rif ();

    assign rif.ready = ready;

    copro_result_buffer #(
        .Depth(DEPTH), .XLEN(32), .hartid_t(logic [1:0]), .id_t(logic [3:0])
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .issue_fire_i(fire),
        .issue_ready_o(issue_ready),
        .alu_valid_i(av),
        .alu_result_i(a_entry[43:12]),
        .alu_hartid_i(a_entry[11:10]),
        .alu_id_i(a_entry[9:6]),
        .alu_rd_i(a_entry[5:1]),
        .alu_we_i(a_entry[0]),
        .result_if(rif),
        .count_o(count),
        .overflow_o(overflow)
    );

    function automatic logic [EW-1:0] rand_entry(input int id);
        return {32'($urandom), 2'($urandom_range(0, 3)), 4'(id),
                5'($urandom_range(0, 31)), 1'($urandom_range(0, 1))};
    endfunction

    // credit rule: entries kept next cycle plus pending result must be < Depth
    function automatic logic exp_ready();
        int need;
        need = exp_q.size() - ((exp_q.size() > 0 && ready) ? 1 : 0) + m_inflight;
        return need < DEPTH;
    endfunction

    function automatic logic [48:0] obs_state();
        logic [EW-1:0] h;
        h = rif.valid ? {rif.data, rif.hartid, rif.id, rif.rd, rif.we} : '0;
        return {rif.valid, count, overflow, h};
    endfunction

    function automatic logic [48:0] exp_state();
        logic [EW-1:0] h;
        h = (exp_q.size() > 0) ? exp_q[0] : '0;
        return {exp_q.size() > 0, 3'(exp_q.size()), m_ovf, h};
    endfunction

    // one clock edge: advance the model from the inputs seen at that edge
    task automatic tick();
        @(posedge clk);
        if (rst) begin
            exp_q.delete();
            m_inflight = 0;
            m_ovf = 1'b0;
        end else begin
            if (exp_q.size() > 0 && ready) void'(exp_q.pop_front());
            if (av) begin
                if (exp_q.size() < DEPTH) exp_q.push_back(a_entry);
                else m_ovf = 1'b1;
            end
            if (fire) m_inflight = 1;
            else if (av) m_inflight = 0;
        end
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; fire = 1'b0; av = 1'b0; ready = 1'b0;
        tick();
        tick();
        n_vec++;
        if (obs_state() !== exp_state()) begin
            n_err++; $display("FAIL reset_state got=%h want=%h", obs_state(), exp_state());
        end
        n_vec++;
        if (issue_ready !== 1'b1) begin
            n_err++; $display("FAIL reset_issue_ready got=%b want=1", issue_ready);
        end
        n_vec++;
        if ({rif.data, rif.hartid, rif.id, rif.rd, rif.we} !== 44'h0) begin
            n_err++; $display("FAIL reset_head got=%h want=0", {rif.data, rif.hartid, rif.id, rif.rd, rif.we});
        end
        rst = 1'b0;
    endtask

    task automatic test_single();
        logic [EW-1:0] e;
        e = {32'h0000_0005, 2'd0, 4'd3, 5'd7, 1'b1};
        fire = 1'b1;
        tick();
        fire = 1'b0; av = 1'b1; a_entry = e; ready = 1'b1;
        tick();
        av = 1'b0;
        n_vec++;
        if (obs_state() !== {1'b1, 3'd1, 1'b0, e}) begin
            n_err++; $display("FAIL single_visible got=%h want=%h", obs_state(), {1'b1, 3'd1, 1'b0, e});
        end
        tick();
        n_vec++;
        if (obs_state() !== exp_state() || count !== 3'd0) begin
            n_err++; $display("FAIL single_popped got=%h want=%h", obs_state(), exp_state());
        end
    endtask

    task automatic test_fill();
        int accepted;
        accepted = 0;
        ready = 1'b0; fire = 1'b0; av = 1'b0;
        #1;
        for (int c = 0; c < 12; c++) begin
            n_vec++;
            if (issue_ready !== exp_ready()) begin
                n_err++; $display("FAIL fill_credit cycle=%0d got=%b want=%b", c, issue_ready, exp_ready());
            end
            av = fire;
            a_entry = rand_entry(c);
            fire = issue_ready;
            if (fire) accepted++;
            if (!fire && !av) break;
            tick();
        end
        n_vec++;
        if (accepted != 4) begin
            n_err++; $display("FAIL fill_accepted got=%0d want=4", accepted);
        end
        n_vec++;
        if (obs_state() !== exp_state() || count !== 3'd4 || overflow !== 1'b0) begin
            n_err++; $display("FAIL fill_state got=%h want=%h", obs_state(), exp_state());
        end
        n_vec++;
        if (issue_ready !== 1'b0) begin
            n_err++; $display("FAIL fill_no_credit got=%b want=0", issue_ready);
        end
    endtask

    task automatic test_full_stream();
        ready = 1'b1; fire = 1'b0;
        for (int c = 0; c < 6; c++) begin
            av = 1'b1;
            a_entry = rand_entry(8 + c);
            #1;
            n_vec++;
            if (issue_ready !== exp_ready()) begin
                n_err++; $display("FAIL stream_credit cycle=%0d got=%b want=%b", c, issue_ready, exp_ready());
            end
            tick();
            n_vec++;
            if (obs_state() !== exp_state() || count !== 3'd4) begin
                n_err++; $display("FAIL stream_state cycle=%0d got=%h want=%h", c, obs_state(), exp_state());
            end
        end
        av = 1'b0; ready = 1'b0;
    endtask

    task automatic test_overflow();
        ready = 1'b0; av = 1'b1; fire = 1'b0;
        a_entry = rand_entry(15);
        tick();
        av = 1'b0;
        n_vec++;
        if (obs_state() !== exp_state() || overflow !== 1'b1) begin
            n_err++; $display("FAIL overflow_drop got=%h want=%h", obs_state(), exp_state());
        end
        tick(); tick(); tick();
        n_vec++;
        if (obs_state() !== exp_state()) begin
            n_err++; $display("FAIL overflow_sticky got=%h want=%h", obs_state(), exp_state());
        end
    endtask

    task automatic test_wrap();
        int id;
        int popped;
        rst = 1'b1; av = 1'b0; fire = 1'b0; ready = 1'b0;
        tick();
        rst = 1'b0;
        id = 0;
        popped = 0;
        for (int c = 0; c < 300 && popped < 10; c++) begin
            ready = 1'($urandom_range(0, 1));
            av = (id < 10) && (exp_q.size() < DEPTH) && ($urandom_range(0, 1) == 1);
            a_entry = rand_entry(id);
            #1;
            n_vec++;
            if (issue_ready !== exp_ready()) begin
                n_err++; $display("FAIL wrap_credit cycle=%0d got=%b want=%b", c, issue_ready, exp_ready());
            end
            if (rif.valid && ready) begin
                n_vec++;
                if (rif.id !== 4'(popped)) begin
                    n_err++; $display("FAIL wrap_order got=%0d want=%0d", rif.id, popped);
                end
                popped++;
            end
            if (av) id++;
            tick();
            n_vec++;
            if (obs_state() !== exp_state()) begin
                n_err++; $display("FAIL wrap_state cycle=%0d got=%h want=%h", c, obs_state(), exp_state());
            end
        end
        av = 1'b0; ready = 1'b0;
        n_vec++;
        if (popped != 10) begin
            n_err++; $display("FAIL wrap_done got=%0d want=10", popped);
        end
    endtask

    task automatic test_reset_mid();
        ready = 1'b0; av = 1'b0;
        for (int c = 0; c < 4; c++) begin
            fire = 1'b1;
            av = (c > 0);
            a_entry = rand_entry(c);
            tick();
        end
        fire = 1'b0; av = 1'b0;
        n_vec++;
        if (count !== 3'd3) begin
            n_err++; $display("FAIL mid_prefill got=%0d want=3", count);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_vec++;
        if (obs_state() !== exp_state() || rif.valid !== 1'b0 || count !== 3'd0 || issue_ready !== 1'b1) begin
            n_err++; $display("FAIL mid_reset got=%h/%b want=%h/1", obs_state(), issue_ready, exp_state());
        end
        av = 1'b1;
        a_entry = rand_entry(9);
        tick();
        av = 1'b0;
        n_vec++;
        if (obs_state() !== exp_state() || count !== 3'd1) begin
            n_err++; $display("FAIL mid_late_push got=%h want=%h", obs_state(), exp_state());
        end
        n_vec++;
        if (issue_ready !== exp_ready()) begin
            n_err++; $display("FAIL mid_credit got=%b want=%b", issue_ready, exp_ready());
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill();
        test_full_stream();
        test_overflow();
        test_wrap();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
